// File: rtl/esm_issue_scheduler.sv
// Instruction-buffer owner and issue stage for the ESM dependency analyser.
// Define ESM_ISSUE_RR_EN for round-robin issue selection; default is lowest-index priority.
//
// Per-entry state | meaning
// ST_FREE         | slot empty, allocatable
// ST_WAIT         | instruction stored, waiting for analyser to clear dependencies
// ST_ISSUED       | sent to (or held in) the issue register, awaiting completion
module esm_issue_scheduler #(
    parameter int Instruction_word_size = 32,
    parameter int bs                    = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             alloc_valid_i,
    output logic                             alloc_ready_o,
    output logic [$clog2(bs)-1:0]            alloc_index_o,
    input  logic [Instruction_word_size-1:0] instr_in_i,
    input  logic [0:bs-1]                    independent_instr_i,
    output logic [0:bs-1]                    valid_entries_o,
    output logic                             issue_valid_o,
    input  logic                             issue_ready_i,
    output logic [$clog2(bs)-1:0]            issue_index_o,
    output logic [Instruction_word_size-1:0] issue_instr_o,
    input  logic                             complete_valid_i,
    input  logic [$clog2(bs)-1:0]            complete_index_i,
    output logic [$clog2(bs):0]              occupancy_o
);
    localparam int IDX_W = $clog2(bs);
    localparam logic [1:0] ST_FREE   = 2'b00;
    localparam logic [1:0] ST_WAIT   = 2'b01;
    localparam logic [1:0] ST_ISSUED = 2'b10;

    logic [1:0]                       state_q [bs];
    logic [1:0]                       state_d [bs];
    logic [Instruction_word_size-1:0] instr_q [bs];
    logic [IDX_W:0]                   occ_q, occ_d;
    logic                             issue_valid_q, issue_valid_d;
    logic [IDX_W-1:0]                 issue_idx_q, issue_idx_d;
    logic [Instruction_word_size-1:0] issue_instr_q, issue_instr_d;

    logic [bs-1:0]    free_vec, elig_vec;
    logic             alloc_found, sel_found;
    logic [IDX_W-1:0] alloc_idx, sel_idx;
    logic             accept, cmpl_ok, load_en, do_issue;

    always_comb begin
        for (int i = 0; i < bs; i++) begin
            free_vec[i]        = (state_q[i] == ST_FREE);
            elig_vec[i]        = independent_instr_i[i] & (state_q[i] == ST_WAIT);
            valid_entries_o[i] = (state_q[i] != ST_FREE);
        end
    end

    // Descending scan so the lowest free index is the last write.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
    end

`ifdef ESM_ISSUE_RR_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] cand;

    // Offsets wrap naturally because bs is a power of two.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = bs - 1; k >= 0; k--) begin
            cand = rr_ptr_q + IDX_W'(k);
            if (elig_vec[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
        rr_ptr_d = do_issue ? sel_idx + IDX_W'(1) : rr_ptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end
`else
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = bs - 1; k >= 0; k--) begin
            if (elig_vec[k]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(k);
            end
        end
    end
`endif

    always_comb begin
        accept   = alloc_valid_i & alloc_found;
        cmpl_ok  = complete_valid_i & (state_q[complete_index_i] == ST_ISSUED);
        load_en  = ~issue_valid_q | issue_ready_i;
        do_issue = load_en & sel_found;

        for (int i = 0; i < bs; i++) begin
            state_d[i] = state_q[i];
            if (accept && alloc_idx == IDX_W'(i))          state_d[i] = ST_WAIT;
            if (cmpl_ok && complete_index_i == IDX_W'(i))  state_d[i] = ST_FREE;
            if (do_issue && sel_idx == IDX_W'(i))          state_d[i] = ST_ISSUED;
        end

        issue_valid_d = issue_valid_q;
        issue_idx_d   = issue_idx_q;
        issue_instr_d = issue_instr_q;
        if (load_en) begin
            issue_valid_d = sel_found;
            if (sel_found) begin
                issue_idx_d   = sel_idx;
                issue_instr_d = instr_q[sel_idx];
            end
        end

        case ({accept, cmpl_ok})
            2'b10:   occ_d = occ_q + (IDX_W+1)'(1);
            2'b01:   occ_d = occ_q - (IDX_W+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < bs; i++) state_q[i] <= ST_FREE;
            occ_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
            issue_instr_q <= '0;
        end else begin
            for (int i = 0; i < bs; i++) state_q[i] <= state_d[i];
            occ_q         <= occ_d;
            issue_valid_q <= issue_valid_d;
            issue_idx_q   <= issue_idx_d;
            issue_instr_q <= issue_instr_d;
        end
    end

    // Slot contents are only meaningful while the slot is non-FREE, so no reset.
    always_ff @(posedge clk_i) begin
        if (accept) instr_q[alloc_idx] <= instr_in_i;
    end

    assign alloc_ready_o = alloc_found;
    assign alloc_index_o = alloc_idx;
    assign issue_valid_o = issue_valid_q;
    assign issue_index_o = issue_idx_q;
    assign issue_instr_o = issue_instr_q;
    assign occupancy_o   = occ_q;
endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Self-checking bench for esm_issue_scheduler: slot-level behavioural model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_esm_issue_scheduler;
    localparam int W  = 32;
    localparam int BS = 16;
    localparam int IW = 4;
`ifdef ESM_ISSUE_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alloc_valid;
    logic          alloc_ready_o;
    logic [IW-1:0] alloc_index_o;
    logic [W-1:0]  instr_in;
    logic [0:BS-1] indep;
    logic [0:BS-1] valid_entries_o;
    logic          issue_valid_o;
    logic          issue_ready;
    logic [IW-1:0] issue_index_o;
    logic [W-1:0]  issue_instr_o;
    logic          complete_valid;
    logic [IW-1:0] complete_index;
    logic [IW:0]   occupancy_o;

    esm_issue_scheduler #(.Instruction_word_size(W), .bs(BS)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .alloc_valid_i       (alloc_valid),
        .alloc_ready_o       (alloc_ready_o),
        .alloc_index_o       (alloc_index_o),
        .instr_in_i          (instr_in),
        .independent_instr_i (indep),
        .valid_entries_o     (valid_entries_o),
        .issue_valid_o       (issue_valid_o),
        .issue_ready_i       (issue_ready),
        .issue_index_o       (issue_index_o),
        .issue_instr_o       (issue_instr_o),
        .complete_valid_i    (complete_valid),
        .complete_index_i    (complete_index),
        .occupancy_o         (occupancy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: slot status 0 = empty, 1 = waiting, 2 = issued.
    int           m_st  [BS];
    logic [W-1:0] m_mem [BS];
    bit           m_iv;
    int           m_idx;
    logic [W-1:0] m_ins;
    int           m_ptr;

    function automatic int m_first_free();
        for (int i = 0; i < BS; i++) if (m_st[i] == 0) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < BS; i++) if (m_st[i] != 0) c++;
        return c;
    endfunction

    function automatic logic [0:BS-1] m_valid_vec();
        logic [0:BS-1] v;
        for (int i = 0; i < BS; i++) v[i] = (m_st[i] != 0);
        return v;
    endfunction

    task automatic model_step();
        int nst[BS];
        int ff;
        int sel;
        int j;
        for (int i = 0; i < BS; i++) nst[i] = m_st[i];
        ff = m_first_free();
        if (alloc_valid && ff >= 0) begin
            nst[ff]   = 1;
            m_mem[ff] = instr_in;
        end
        if (complete_valid && m_st[complete_index] == 2) nst[complete_index] = 0;
        if (!m_iv || issue_ready) begin
            sel = -1;
            for (int k = 0; k < BS; k++) begin
                j = RR ? (m_ptr + k) % BS : k;
                if (sel < 0 && indep[j] && m_st[j] == 1) sel = j;
            end
            if (sel >= 0) begin
                nst[sel] = 2;
                m_iv     = 1'b1;
                m_idx    = sel;
                m_ins    = m_mem[sel];
                m_ptr    = (sel + 1) % BS;
            end else begin
                m_iv = 1'b0;
            end
        end
        for (int i = 0; i < BS; i++) m_st[i] = nst[i];
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BS; i++) m_st[i] = 0;
            m_iv  = 1'b0;
            m_idx = 0;
            m_ins = '0;
            m_ptr = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        int ff;
        if (!rst) begin
            ff = m_first_free();
            check("alloc_ready", alloc_ready_o, ff >= 0);
            if (ff >= 0) check("alloc_index", alloc_index_o, ff);
            check("valid_entries", valid_entries_o, m_valid_vec());
            check("occupancy", occupancy_o, m_count());
            check("issue_valid", issue_valid_o, m_iv);
            if (m_iv) begin
                check("issue_index", issue_index_o, m_idx);
                check("issue_instr", issue_instr_o, m_ins);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_n(input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) begin
            alloc_valid = 1'b1;
            instr_in    = base + W'(i);
            tick();
        end
        alloc_valid = 1'b0;
    endtask

    task automatic complete(input int idx);
        complete_valid = 1'b1;
        complete_index = IW'(idx);
        tick();
        complete_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alloc_valid = 1'b0; indep = '0; complete_valid = 1'b0; issue_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int exp_first;
    int seq2 [2];
    int seq3 [3];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        alloc_valid = 1'b0; instr_in = '0; indep = '0; issue_ready = 1'b0;
        complete_valid = 1'b0; complete_index = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_entries", valid_entries_o, 0);
        check("rst_alloc_ready", alloc_ready_o, 1);
        check("rst_alloc_index", alloc_index_o, 0);
        check("rst_issue_valid", issue_valid_o, 0);
        check("rst_issue_index", issue_index_o, 0);
        check("rst_issue_instr", issue_instr_o, 0);
        check("rst_occupancy", occupancy_o, 0);
        rst = 1'b0;

        // First instruction: 2-cycle alloc-to-issue
        alloc_valid = 1'b1; instr_in = 32'h0050_0093; indep[0] = 1'b1;
        #1 check("first_alloc_index", alloc_index_o, 0);
        tick();
        alloc_valid = 1'b0;
        #1 check("first_valid_entries", valid_entries_o, 16'h8000);
        check("first_not_yet_issued", issue_valid_o, 0);
        tick();
        check("first_issue_valid", issue_valid_o, 1);
        check("first_issue_index", issue_index_o, 0);
        check("first_issue_instr", issue_instr_o, 32'h0050_0093);
        issue_ready = 1'b1; indep = '0;
        tick();
        complete(0);
        #1 check("first_freed_occ", occupancy_o, 0);

        // Fill to full, offer one extra, then free slot 5
        alloc_n(BS, 32'hA000_0000);
        alloc_valid = 1'b1; instr_in = 32'hDEAD_BEEF;
        tick();
        alloc_valid = 1'b0;
        #1 check("full_occ", occupancy_o, 16);
        check("full_alloc_ready", alloc_ready_o, 0);
        indep[5] = 1'b1;
        tick();
        check("full_issue5", issue_index_o, 5);
        check("full_issue5_instr", issue_instr_o, 32'hA000_0005);
        indep = '0;
        tick();
        complete(5);
        #1 check("free5_alloc_ready", alloc_ready_o, 1);
        check("free5_alloc_index", alloc_index_o, 5);
        check("free5_occ", occupancy_o, 15);

        // Completion on a waiting entry is ignored
        complete(7);
        #1 check("cmpl_wait_occ", occupancy_o, 15);
        check("cmpl_wait_valid", valid_entries_o, 16'hFBFF);

        // Back-pressure: three eligible, issue register holds
        issue_ready = 1'b0;
        indep[1] = 1'b1; indep[4] = 1'b1; indep[8] = 1'b1;
        tick();
        exp_first = RR ? 8 : 1;
        for (int c = 0; c < 10; c++) begin
            check("hold_valid", issue_valid_o, 1);
            check("hold_index", issue_index_o, exp_first);
            check("hold_instr", issue_instr_o, 32'hA000_0000 + exp_first);
            tick();
        end
        issue_ready = 1'b1;
        if (RR) begin seq2[0] = 1; seq2[1] = 4; end
        else    begin seq2[0] = 4; seq2[1] = 8; end
        tick();
        check("release_second", issue_index_o, seq2[0]);
        tick();
        check("release_third", issue_index_o, seq2[1]);
        tick();
        check("release_drained", issue_valid_o, 0);
        indep = '0;

        // Issue order with entries 2,3,9 eligible and pointer at 4
        do_reset();
        issue_ready = 1'b1;
        alloc_n(10, 32'hB000_0000);
        indep[3] = 1'b1;
        tick();
        indep = '0;
        tick();
        complete(3);
        alloc_valid = 1'b1; instr_in = 32'hC000_0003;
        #1 check("order_realloc_index", alloc_index_o, 3);
        tick();
        alloc_valid = 1'b0;
        indep[2] = 1'b1; indep[3] = 1'b1; indep[9] = 1'b1;
        if (RR) begin seq3[0] = 9; seq3[1] = 2; seq3[2] = 3; end
        else    begin seq3[0] = 2; seq3[1] = 3; seq3[2] = 9; end
        for (int k = 0; k < 3; k++) begin
            tick();
            check("order_valid", issue_valid_o, 1);
            check("order_index", issue_index_o, seq3[k]);
        end
        indep = '0;
        tick();

        // Async reset mid-operation
        do_reset();
        issue_ready = 1'b0;
        alloc_n(6, 32'hE000_0000);
        indep[0] = 1'b1;
        tick();
        check("pre_rst_issue_valid", issue_valid_o, 1);
        check("pre_rst_occ", occupancy_o, 6);
        #2 rst = 1'b1;
        #1;
        check("arst_valid_entries", valid_entries_o, 0);
        check("arst_issue_valid", issue_valid_o, 0);
        check("arst_issue_index", issue_index_o, 0);
        check("arst_issue_instr", issue_instr_o, 0);
        check("arst_occ", occupancy_o, 0);
        check("arst_alloc_ready", alloc_ready_o, 1);
        check("arst_alloc_index", alloc_index_o, 0);
        indep = '0;
        tick();
        rst = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
